// File: rtl/elevator_scan_ctrl.sv
// Single-car LOOK elevator controller: latched car/hall call bitmaps,
// direction-discriminating stops, timed door dwell with obstruction hold.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_W     = $clog2(NUM_FLOORS),
    parameter int DOOR_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] car_req,
    input  logic [NUM_FLOORS-1:0] hall_up_req,
    input  logic [NUM_FLOORS-1:0] hall_dn_req,
    input  logic                  at_floor,
    input  logic                  door_hold,
    output logic [1:0]            state,
    output logic                  motor_up,
    output logic                  motor_dn,
    output logic                  door_open,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] car_pend,
    output logic [NUM_FLOORS-1:0] hall_up_pend,
    output logic [NUM_FLOORS-1:0] hall_dn_pend,
    output logic                  sensor_err
);

    localparam int TIMER_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TIMER_W-1:0]    DWELL   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]    TOP     = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] ONES    = '1;
    localparam logic [NUM_FLOORS-1:0] UP_MASK = ONES >> 1;
    localparam logic [NUM_FLOORS-1:0] DN_MASK = ONES << 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DN   = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        R_OWN,
        R_AHEAD,
        R_OPP,
        R_BEHIND,
        R_NONE
    } rule_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [FLOOR_W-1:0]   floor_d, eval_floor;
    logic                 dir_d, err_d;
    logic [NUM_FLOORS-1:0] clr_car, clr_up, clr_dn;
    logic [NUM_FLOORS-1:0] absorb_car, absorb_up, absorb_dn;
    logic [NUM_FLOORS-1:0] up_req_m, dn_req_m;
    logic                  hit;
    rule_t                 rule;

    function automatic rule_t decide(
        input logic [FLOOR_W-1:0]    f,
        input logic                  d,
        input logic [NUM_FLOORS-1:0] c,
        input logic [NUM_FLOORS-1:0] u,
        input logic [NUM_FLOORS-1:0] dn
    );
        logic [NUM_FLOORS-1:0] any_p;
        logic above, below, own, opp, ahead, behind;
        any_p  = c | u | dn;
        above  = |((any_p >> f) >> 1);
        below  = |(any_p & ~(ONES << f));
        own    = c[f] | (d ? u[f] : dn[f]);
        opp    = d ? dn[f] : u[f];
        ahead  = d ? above : below;
        behind = d ? below : above;
        if (own)         decide = R_OWN;
        else if (ahead)  decide = R_AHEAD;
        else if (opp)    decide = R_OPP;
        else if (behind) decide = R_BEHIND;
        else             decide = R_NONE;
    endfunction

    assign up_req_m = hall_up_req & UP_MASK;
    assign dn_req_m = hall_dn_req & DN_MASK;

    // Moving states evaluate the stop decision at the floor being arrived at.
    always_comb begin
        eval_floor = cur_floor;
        if (state_q == MOVE_UP && cur_floor != TOP)
            eval_floor = cur_floor + 1'b1;
        else if (state_q == MOVE_DN && cur_floor != '0)
            eval_floor = cur_floor - 1'b1;
    end

    always_comb begin
        rule = decide(eval_floor, dir_up, car_pend, hall_up_pend, hall_dn_pend);
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        floor_d    = cur_floor;
        dir_d      = dir_up;
        err_d      = sensor_err;
        clr_car    = '0;
        clr_up     = '0;
        clr_dn     = '0;
        absorb_car = '0;
        absorb_up  = '0;
        absorb_dn  = '0;
        hit        = car_req[cur_floor] |
                     (dir_up ? up_req_m[cur_floor] : dn_req_m[cur_floor]);

        if (at_floor && (state_q == IDLE || state_q == DOOR_OPEN))
            err_d = 1'b1;
        if (at_floor && state_q == MOVE_UP && cur_floor == TOP)
            err_d = 1'b1;
        if (at_floor && state_q == MOVE_DN && cur_floor == '0)
            err_d = 1'b1;

        case (state_q)
            IDLE, MOVE_UP, MOVE_DN: begin
                if (state_q == IDLE || (at_floor && eval_floor != cur_floor)) begin
                    floor_d = eval_floor;
                    case (rule)
                        R_OWN: begin
                            state_d             = DOOR_OPEN;
                            timer_d             = DWELL;
                            clr_car[eval_floor] = 1'b1;
                            clr_up[eval_floor]  = dir_up;
                            clr_dn[eval_floor]  = ~dir_up;
                        end
                        R_AHEAD: state_d = dir_up ? MOVE_UP : MOVE_DN;
                        R_OPP: begin
                            state_d            = DOOR_OPEN;
                            timer_d            = DWELL;
                            dir_d              = ~dir_up;
                            clr_up[eval_floor] = ~dir_up;
                            clr_dn[eval_floor] = dir_up;
                        end
                        R_BEHIND: begin
                            // A moving car always halts for a cycle before reversing.
                            if (state_q == IDLE) begin
                                dir_d   = ~dir_up;
                                state_d = dir_up ? MOVE_DN : MOVE_UP;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            DOOR_OPEN: begin
                absorb_car[cur_floor] = 1'b1;
                absorb_up[cur_floor]  = dir_up;
                absorb_dn[cur_floor]  = ~dir_up;
                if (door_hold || hit)
                    timer_d = DWELL;
                else if (timer_q == '0)
                    state_d = IDLE;
                else
                    timer_d = timer_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cur_floor    <= '0;
            dir_up       <= 1'b1;
            car_pend     <= '0;
            hall_up_pend <= '0;
            hall_dn_pend <= '0;
            sensor_err   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cur_floor    <= floor_d;
            dir_up       <= dir_d;
            sensor_err   <= err_d;
            car_pend     <= (car_pend & ~clr_car) | (car_req & ~absorb_car);
            hall_up_pend <= (hall_up_pend & ~clr_up) | (up_req_m & ~absorb_up);
            hall_dn_pend <= (hall_dn_pend & ~clr_dn) | (dn_req_m & ~absorb_dn);
        end
    end

    assign state     = state_q;
    assign motor_up  = (state_q == MOVE_UP);
    assign motor_dn  = (state_q == MOVE_DN);
    assign door_open = (state_q == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl, 8 floors with a 4-cycle door dwell.
module tb_elevator_scan_ctrl;

    localparam int NF = 8;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] car_req = '0;
    logic [NF-1:0] hall_up_req = '0;
    logic [NF-1:0] hall_dn_req = '0;
    logic          at_floor = 1'b0;
    logic          door_hold = 1'b0;
    logic [1:0]    state;
    logic          motor_up, motor_dn, door_open, dir_up, sensor_err;
    logic [FW-1:0] cur_floor;
    logic [NF-1:0] car_pend, hall_up_pend, hall_dn_pend;

    int n_checks = 0;
    int n_fail   = 0;
    int motor_cycles = 0;
    int n;
    int m0;

    elevator_scan_ctrl #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .DOOR_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .car_req     (car_req),
        .hall_up_req (hall_up_req),
        .hall_dn_req (hall_dn_req),
        .at_floor    (at_floor),
        .door_hold   (door_hold),
        .state       (state),
        .motor_up    (motor_up),
        .motor_dn    (motor_dn),
        .door_open   (door_open),
        .cur_floor   (cur_floor),
        .dir_up      (dir_up),
        .car_pend    (car_pend),
        .hall_up_pend(hall_up_pend),
        .hall_dn_pend(hall_dn_pend),
        .sensor_err  (sensor_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (motor_up || motor_dn) motor_cycles++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        car_req = '0; hall_up_req = '0; hall_dn_req = '0;
        at_floor = 1'b0; door_hold = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_req(input logic [NF-1:0] c, input logic [NF-1:0] u, input logic [NF-1:0] d);
        car_req = c; hall_up_req = u; hall_dn_req = d;
        tick();
        car_req = '0; hall_up_req = '0; hall_dn_req = '0;
    endtask

    task automatic arrive();
        at_floor = 1'b1;
        tick();
        at_floor = 1'b0;
    endtask

    task automatic door_len(output int len);
        len = 0;
        while (door_open && len < 64) begin
            len++;
            tick();
        end
    endtask

    initial begin
        do_reset();
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_floor", 32'(cur_floor), 0);
        check_eq("rst_dir", 32'(dir_up), 1);
        check_eq("rst_pend", 32'(car_pend | hall_up_pend | hall_dn_pend), 0);
        check_eq("rst_outs", 32'({motor_up, motor_dn, door_open, sensor_err}), 0);

        // Call at the current floor
        m0 = motor_cycles;
        pulse_req(8'h01, 8'h00, 8'h00);
        check_eq("s1_pend_latched", 32'(car_pend), 32'h01);
        check_eq("s1_door_not_yet", 32'(door_open), 0);
        tick();
        check_eq("s1_door_open", 32'(door_open), 1);
        check_eq("s1_pend_cleared", 32'(car_pend), 0);
        door_len(n);
        check_eq("s1_door_len", 32'(n + 1), 4 + 1);
        check_eq("s1_idle", 32'(state), 0);
        check_eq("s1_no_motor", 32'(motor_cycles - m0), 0);

        // Up trip passing a down call, then reverse to serve it
        pulse_req(8'h20, 8'h00, 8'h08);
        check_eq("s2_pend", 32'({car_pend, hall_dn_pend}), 32'h2008);
        tick();
        check_eq("s2_move_up", 32'({state, motor_up}), 32'b011);
        repeat (3) arrive();
        check_eq("s2_pass_3", 32'({state, cur_floor}), 32'b01_011);
        repeat (2) arrive();
        check_eq("s2_stop_5", 32'({state, cur_floor}), 32'b11_101);
        check_eq("s2_car5_clr", 32'(car_pend), 0);
        check_eq("s2_motor_off", 32'(motor_up), 0);
        door_len(n);
        check_eq("s2_door_len_5", 32'(n), 4);
        check_eq("s2_idle_5", 32'(state), 0);
        tick();
        check_eq("s2_move_dn", 32'({state, dir_up, motor_dn}), 32'b1001);
        repeat (2) arrive();
        check_eq("s2_stop_3", 32'({state, cur_floor, dir_up}), 32'b11_011_0);
        check_eq("s2_dn3_clr", 32'(hall_dn_pend), 0);
        door_len(n);
        check_eq("s2_door_len_3", 32'(n), 4);

        // Hall-up call added while moving
        do_reset();
        pulse_req(8'h04, 8'h00, 8'h00);
        tick();
        check_eq("s3_move_up", 32'(state), 1);
        arrive();
        pulse_req(8'h00, 8'h10, 8'h00);
        check_eq("s3_up4_pend", 32'(hall_up_pend), 32'h10);
        arrive();
        check_eq("s3_stop_2", 32'({state, cur_floor}), 32'b11_010);
        door_len(n);
        check_eq("s3_door_len_2", 32'(n), 4);
        tick();
        check_eq("s3_move_again", 32'(state), 1);
        repeat (2) arrive();
        check_eq("s3_stop_4", 32'({state, cur_floor}), 32'b11_100);
        door_len(n);
        check_eq("s3_final", 32'({state, cur_floor}), 32'b00_100);
        check_eq("s3_all_clr", 32'(car_pend | hall_up_pend | hall_dn_pend), 0);

        // Door hold and absorbed re-press at floor 2
        pulse_req(8'h04, 8'h00, 8'h00);
        tick();
        check_eq("s4_move_dn", 32'({state, dir_up}), 32'b100);
        repeat (2) arrive();
        check_eq("s4_stop_2", 32'({state, cur_floor}), 32'b11_010);
        n = 0;
        door_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (door_open) n++;
            tick();
        end
        door_hold = 1'b0;
        while (door_open && n < 64) begin
            n++;
            tick();
        end
        check_eq("s4_hold_len", 32'(n), 14);
        pulse_req(8'h04, 8'h00, 8'h00);
        tick();
        check_eq("s4_reopen", 32'(door_open), 1);
        n = 1;
        tick();
        if (door_open) n++;
        car_req = 8'h04;
        tick();
        car_req = '0;
        check_eq("s4_absorbed", 32'(car_pend), 0);
        while (door_open && n < 64) begin
            n++;
            tick();
        end
        check_eq("s4_reload_len", 32'(n), 6);
        check_eq("s4_after", 32'({state, car_pend}), 0);

        // Sensor pulse while idle
        check_eq("s5_err_clear", 32'(sensor_err), 0);
        pulse_req(8'h02, 8'h00, 8'h00);
        tick();
        arrive();
        check_eq("s5_stop_1", 32'({state, cur_floor}), 32'b11_001);
        door_len(n);
        check_eq("s5_door_len", 32'(n), 4);
        arrive();
        check_eq("s5_err_set", 32'({sensor_err, state, cur_floor}), 32'b1_00_001);
        repeat (3) tick();
        check_eq("s5_err_sticky", 32'(sensor_err), 1);

        // Asynchronous reset mid-travel
        pulse_req(8'h40, 8'h00, 8'h00);
        tick();
        check_eq("s6_move_up", 32'({state, dir_up}), 32'b011);
        repeat (2) arrive();
        check_eq("s6_at_3", 32'({state, cur_floor, car_pend}), {21'd0, 2'b01, 3'b011, 8'h40});
        rst_n = 1'b0;
        #2;
        check_eq("s6_rst_state", 32'({state, cur_floor, dir_up}), 32'b00_000_1);
        check_eq("s6_rst_pend", 32'(car_pend | hall_up_pend | hall_dn_pend), 0);
        check_eq("s6_rst_outs", 32'({motor_up, sensor_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Masked hall bits never latch
        pulse_req(8'h00, 8'h80, 8'h01);
        check_eq("mask_up7", 32'(hall_up_pend), 0);
        check_eq("mask_dn0", 32'(hall_dn_pend), 0);
        tick();
        check_eq("mask_idle", 32'(state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
